mem_port_arbiter: RTL and testbench

//  Shares one single-port synchronous memory between the core's instruction-fetch port and data port.

---
 rtl/mem_port_arbiter_pkg.sv | 57 +++++
 rtl/mem_port_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared types and constants for the unified-memory arbiter that sits between
// the core's instruction-fetch port, its data port and a single-port
// synchronous memory macro.
//   arb_state_e  : sequencing FSM states (2-bit encodings)
//   arb_owner_e  : which requester currently owns the memory
//   MEM_LAT_MAX  : largest supported memory read latency
//   arb_pick     : grant decision when the arbiter is idle
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        ARB_OWN_I = 1'b0,
        ARB_OWN_D = 1'b1
    } arb_owner_e;

    localparam int MEM_LAT_MAX = 4;

    // Grant decision. Only meaningful when at least one request is present;
    // with a single request that requester wins. With both present, fixed
    // priority favours the data port, round-robin favours whoever did not
    // own the memory last.
    function automatic arb_owner_e arb_pick(
        input logic       i_req,
        input logic       d_req,
        input arb_owner_e last_owner,
        input logic       rr_mode
    );
        arb_owner_e pick;
        pick = ARB_OWN_I;
        if (i_req && d_req) begin
            if (rr_mode) begin
                if (last_owner == ARB_OWN_D) begin
                    pick = ARB_OWN_I;
                end else begin
                    pick = ARB_OWN_D;
                end
            end else begin
                pick = ARB_OWN_D;
            end
        end else if (d_req) begin
            pick = ARB_OWN_D;
        end else begin
            pick = ARB_OWN_I;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port synchronous memory between the instruction-fetch
// port and the data port. One transaction is in flight at a time:
//   IDLE -> ISSUE -> WAIT -> RESP -> IDLE   (loads / fetches)
//   IDLE -> ISSUE -> RESP -> IDLE           (stores)
// Ports:
//   clk, rst                     clock (rising edge), async active-high reset
//   i_req/i_addr                 fetch request and byte address
//   i_rdata/i_valid              fetched word and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata    data request (load when d_we=0, store when 1)
//   d_rdata/d_valid              load data and one-cycle completion pulse
//   m_en/m_we/m_addr/m_wdata     memory strobe/controls, high only in ISSUE
//   m_rdata                      memory read data, MEM_LAT cycles after m_en
// All outputs are driven straight from registers.
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WORD_LEN = 32,
    parameter int MEM_LAT  = 1,
    parameter int PRIO_RR  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [WORD_LEN-1:0] i_addr,
    output logic [WORD_LEN-1:0] i_rdata,
    output logic                i_valid,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [WORD_LEN-1:0] d_addr,
    input  logic [WORD_LEN-1:0] d_wdata,
    output logic [WORD_LEN-1:0] d_rdata,
    output logic                d_valid,
    output logic                m_en,
    output logic                m_we,
    output logic [WORD_LEN-1:0] m_addr,
    output logic [WORD_LEN-1:0] m_wdata,
    input  logic [WORD_LEN-1:0] m_rdata
);

    // Counter preload: WAIT lasts MEM_LAT cycles, capturing on the last one.
    localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);
    localparam logic       RR_MODE  = (PRIO_RR != 0) ? 1'b1 : 1'b0;

    arb_state_e          state_q,      state_d;
    arb_owner_e          owner_q,      owner_d;
    arb_owner_e          last_owner_q, last_owner_d;
    logic [1:0]          lat_cnt_q,    lat_cnt_d;
    logic                we_q,         we_d;
    logic [WORD_LEN-1:0] addr_q,       addr_d;
    logic [WORD_LEN-1:0] wdata_q,      wdata_d;
    logic                m_en_q,       m_en_d;
    logic                m_we_q,       m_we_d;
    logic [WORD_LEN-1:0] m_addr_q,     m_addr_d;
    logic [WORD_LEN-1:0] m_wdata_q,    m_wdata_d;
    logic                i_valid_q,    i_valid_d;
    logic                d_valid_q,    d_valid_d;
    logic [WORD_LEN-1:0] i_rdata_q,    i_rdata_d;
    logic [WORD_LEN-1:0] d_rdata_q,    d_rdata_d;
    arb_owner_e          grant_s;

    assign grant_s = arb_pick(i_req, d_req, last_owner_q, RR_MODE);

    // Next-state and registered-output decode for the sequencing FSM.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        lat_cnt_d    = lat_cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        // Memory controls and valid pulses are single-cycle: default low.
        m_en_d       = 1'b0;
        m_we_d       = 1'b0;
        m_addr_d     = {WORD_LEN{1'b0}};
        m_wdata_d    = {WORD_LEN{1'b0}};
        i_valid_d    = 1'b0;
        d_valid_d    = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (i_req || d_req) begin
                    owner_d = grant_s;
                    if (grant_s == ARB_OWN_D) begin
                        we_d    = d_we;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                    end else begin
                        // Fetches never write.
                        we_d    = 1'b0;
                        addr_d  = i_addr;
                        wdata_d = {WORD_LEN{1'b0}};
                    end
                    // Memory strobe registered here so it is high exactly
                    // during the ISSUE cycle.
                    m_en_d    = 1'b1;
                    m_we_d    = we_d;
                    m_addr_d  = addr_d;
                    m_wdata_d = wdata_d;
                    state_d   = ARB_ISSUE;
                end else begin
                    state_d = ARB_IDLE;
                end
            end

            ARB_ISSUE: begin
                if (we_q) begin
                    // Stores complete without waiting for read data.
                    if (owner_q == ARB_OWN_D) begin
                        d_valid_d = 1'b1;
                    end else begin
                        i_valid_d = 1'b1;
                    end
                    state_d = ARB_RESP;
                end else begin
                    lat_cnt_d = LAT_INIT;
                    state_d   = ARB_WAIT;
                end
            end

            ARB_WAIT: begin
                if (lat_cnt_q == 2'd0) begin
                    if (owner_q == ARB_OWN_D) begin
                        d_rdata_d = m_rdata;
                        d_valid_d = 1'b1;
                    end else begin
                        i_rdata_d = m_rdata;
                        i_valid_d = 1'b1;
                    end
                    state_d = ARB_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                    state_d   = ARB_WAIT;
                end
            end

            ARB_RESP: begin
                last_owner_d = owner_q;
                state_d      = ARB_IDLE;
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State, latched request and output registers; reset drops any
    // in-flight access without a completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= ARB_OWN_I;
            last_owner_q <= ARB_OWN_D;
            lat_cnt_q    <= 2'd0;
            we_q         <= 1'b0;
            addr_q       <= {WORD_LEN{1'b0}};
            wdata_q      <= {WORD_LEN{1'b0}};
            m_en_q       <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= {WORD_LEN{1'b0}};
            m_wdata_q    <= {WORD_LEN{1'b0}};
            i_valid_q    <= 1'b0;
            d_valid_q    <= 1'b0;
            i_rdata_q    <= {WORD_LEN{1'b0}};
            d_rdata_q    <= {WORD_LEN{1'b0}};
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            lat_cnt_q    <= lat_cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            m_en_q       <= m_en_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            i_valid_q    <= i_valid_d;
            d_valid_q    <= d_valid_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign i_rdata = i_rdata_q;
    assign i_valid = i_valid_q;
    assign d_rdata = d_rdata_q;
    assign d_valid = d_valid_q;
    assign m_en    = m_en_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Three arbiter instances, each with its own behavioural memory:
//   0: MEM_LAT=1, fixed priority   1: MEM_LAT=1, round-robin
//   2: MEM_LAT=3, fixed priority
// Memory preload: word[i] = 0xA000_0000 | (i*4), except word[0] = 0x13.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int NI = 3;

    logic        clk;
    logic        rst;
    logic        mem_init;
    logic        i_req   [NI];
    logic [31:0] i_addr  [NI];
    logic [31:0] i_rdata [NI];
    logic        i_valid [NI];
    logic        d_req   [NI];
    logic        d_we    [NI];
    logic [31:0] d_addr  [NI];
    logic [31:0] d_wdata [NI];
    logic [31:0] d_rdata [NI];
    logic        d_valid [NI];
    logic        m_en    [NI];
    logic        m_we    [NI];
    logic [31:0] m_addr  [NI];
    logic [31:0] m_wdata [NI];
    logic [31:0] m_rdata [NI];

    int n_checks = 0;
    int n_errors = 0;
    int both_valid_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LAT = (g == 2) ? 3 : 1;
        localparam int RR  = (g == 1) ? 1 : 0;
        logic [31:0] mem  [256];
        logic [31:0] pipe [4];

        mem_port_arbiter #(.WORD_LEN(32), .MEM_LAT(LAT), .PRIO_RR(RR)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .i_req   (i_req[g]),
            .i_addr  (i_addr[g]),
            .i_rdata (i_rdata[g]),
            .i_valid (i_valid[g]),
            .d_req   (d_req[g]),
            .d_we    (d_we[g]),
            .d_addr  (d_addr[g]),
            .d_wdata (d_wdata[g]),
            .d_rdata (d_rdata[g]),
            .d_valid (d_valid[g]),
            .m_en    (m_en[g]),
            .m_we    (m_we[g]),
            .m_addr  (m_addr[g]),
            .m_wdata (m_wdata[g]),
            .m_rdata (m_rdata[g])
        );

        // Behavioural single-port memory with LAT-cycle read pipeline.
        always @(posedge clk) begin
            if (mem_init) begin
                for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | (32'(i) << 2);
                mem[0] <= 32'h0000_0013;
            end else if (m_en[g] && m_we[g]) begin
                mem[m_addr[g][9:2]] <= m_wdata[g];
            end
            pipe[0] <= (m_en[g] && !m_we[g]) ? mem[m_addr[g][9:2]] : 32'h0;
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end
        assign m_rdata[g] = pipe[LAT-1];
    end

    // Both completion pulses of one instance must never coincide.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (i_valid[k] && d_valid[k]) both_valid_cnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until the selected port's valid is seen (bounded); checks the
    // number of cycles taken and the number of m_en cycles on the way.
    task automatic wait_valid(input int k, input logic is_d, input int exp_cyc,
                              input int exp_men, input string tag);
        int   cyc;
        int   men;
        logic seen;
        cyc  = 0;
        men  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            step();
            cyc++;
            if (m_en[k]) men++;
            seen = is_d ? d_valid[k] : i_valid[k];
        end
        check_eq({tag, "_lat"}, 32'(cyc), 32'(exp_cyc));
        check_eq({tag, "_men"}, 32'(men), 32'(exp_men));
    endtask

    initial begin
        rst      = 1'b1;
        mem_init = 1'b1;
        for (int k = 0; k < NI; k++) begin
            i_req[k] = 1'b0; i_addr[k] = 32'h0;
            d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = 32'h0; d_wdata[k] = 32'h0;
        end
        step();
        step();
        // Reset state.
        check_eq("rst_i_valid", 32'(i_valid[0]), 32'h0);
        check_eq("rst_d_valid", 32'(d_valid[0]), 32'h0);
        check_eq("rst_m_en",    32'(m_en[0]),    32'h0);
        check_eq("rst_m_addr",  m_addr[0],       32'h0);
        check_eq("rst_i_rdata", i_rdata[2],      32'h0);
        rst      = 1'b0;
        mem_init = 1'b0;
        step();

        // Fetch from address 0, MEM_LAT=1.
        i_req[0] = 1'b1; i_addr[0] = 32'h0;
        step();
        check_eq("fetch_m_en",   32'(m_en[0]), 32'h1);
        check_eq("fetch_m_we",   32'(m_we[0]), 32'h0);
        check_eq("fetch_m_addr", m_addr[0],    32'h0);
        wait_valid(0, 1'b0, 2, 0, "fetch");
        check_eq("fetch_rdata",   i_rdata[0],      32'h0000_0013);
        check_eq("fetch_d_valid", 32'(d_valid[0]), 32'h0);
        i_req[0] = 1'b0;
        step();
        check_eq("fetch_pulse1", 32'(i_valid[0]), 32'h0);
        check_eq("idle_m_en",    32'(m_en[0]),    32'h0);

        // Store 0xDEADBEEF to 0x100.
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h100; d_wdata[0] = 32'hDEAD_BEEF;
        step();
        check_eq("st_m_en",    32'(m_en[0]), 32'h1);
        check_eq("st_m_we",    32'(m_we[0]), 32'h1);
        check_eq("st_m_addr",  m_addr[0],    32'h100);
        check_eq("st_m_wdata", m_wdata[0],   32'hDEAD_BEEF);
        wait_valid(0, 1'b1, 1, 0, "st");
        d_req[0] = 1'b0; d_we[0] = 1'b0;
        step();

        // Load back 0x100.
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h100;
        wait_valid(0, 1'b1, 3, 1, "ld");
        check_eq("ld_rdata", d_rdata[0], 32'hDEAD_BEEF);
        d_req[0] = 1'b0;
        step();

        // Simultaneous requests, fixed priority: data first, then fetch.
        i_req[0] = 1'b1; i_addr[0] = 32'h4;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h8;
        step();
        check_eq("prio_m_addr_d", m_addr[0], 32'h8);
        wait_valid(0, 1'b1, 2, 0, "prio_d");
        check_eq("prio_d_rdata", d_rdata[0], 32'hA000_0008);
        d_req[0] = 1'b0;
        wait_valid(0, 1'b0, 4, 1, "prio_i");
        check_eq("prio_i_rdata", i_rdata[0], 32'hA000_0004);
        i_req[0] = 1'b0;
        step();

        // Round-robin with both held high: I, D, I, D.
        i_req[1] = 1'b1; i_addr[1] = 32'h10;
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h20;
        for (int p = 0; p < 4; p++) begin
            int   cyc;
            logic exp_d;
            exp_d = (p % 2 == 1);
            cyc   = 0;
            do begin
                step();
                cyc++;
            end while (!(i_valid[1] || d_valid[1]) && cyc < 20);
            check_eq($sformatf("rr_gap%0d", p), 32'(cyc), (p == 0) ? 32'd3 : 32'd4);
            check_eq($sformatf("rr_own%0d", p), 32'(d_valid[1]), 32'(exp_d));
            if (exp_d) check_eq($sformatf("rr_rd%0d", p), d_rdata[1], 32'hA000_0020);
            else       check_eq($sformatf("rr_rd%0d", p), i_rdata[1], 32'hA000_0010);
        end
        i_req[1] = 1'b0; d_req[1] = 1'b0;
        step();
        step();

        // MEM_LAT=3 load: valid at N+5, single m_en.
        d_req[2] = 1'b1; d_we[2] = 1'b0; d_addr[2] = 32'hC;
        wait_valid(2, 1'b1, 5, 1, "lat3");
        check_eq("lat3_rdata", d_rdata[2], 32'hA000_000C);
        d_req[2] = 1'b0;
        step();

        // Reset asserted while a fetch waits on memory.
        i_req[2] = 1'b1; i_addr[2] = 32'h4;
        step();
        step();
        check_eq("wait_m_en", 32'(m_en[2]), 32'h0);
        rst = 1'b1;
        #1;
        check_eq("mrst_d_rdata", d_rdata[2],      32'h0);
        check_eq("mrst_i_valid", 32'(i_valid[2]), 32'h0);
        check_eq("mrst_m_en",    32'(m_en[2]),    32'h0);
        step();
        i_req[2] = 1'b0;
        rst = 1'b0;
        begin
            int late_valid;
            late_valid = 0;
            for (int c = 0; c < 6; c++) begin
                step();
                if (i_valid[2] || d_valid[2]) late_valid++;
            end
            check_eq("mrst_no_pulse", 32'(late_valid), 32'h0);
        end
        i_req[2] = 1'b1; i_addr[2] = 32'h0;
        wait_valid(2, 1'b0, 5, 1, "post_rst");
        check_eq("post_rst_rdata", i_rdata[2], 32'h0000_0013);
        i_req[2] = 1'b0;
        step();

        check_eq("excl_valid", 32'(both_valid_cnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
